// File: rtl/uart_rx_module.sv
// uart_rx_module
//   8N1 UART receiver feeding the UART transmitter. Synchronises rxd,
//   qualifies the start bit at mid-bit, samples eight data bits LSB first
//   and the stop bit at mid-bit, then publishes the byte on rx_data with a
//   multi-cycle rx_flag strobe that the transmitter edge-detects.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rxd        asynchronous serial input, idle high
//   rx_data    last correctly framed byte
//   rx_flag    high for FLAG_HOLD cycles whenever rx_data is updated
//   frame_err  one-cycle pulse when the stop bit samples low
//   rx_busy    high whenever the receiver is not idle
module uart_rx_module #(
    parameter int unsigned CLKS_PER_BIT = 1433,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int unsigned FLAG_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] FLAG_LOAD = 16'(FLAG_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state_q,     state_d;
    logic        s1_q,        s1_d;
    logic        s2_q,        s2_d;
    logic        s3_q,        s3_d;
    logic [15:0] clk_cnt_q,   clk_cnt_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic [15:0] flag_cnt_q,  flag_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic        fall;

    // Falling edge of the synchronised line: previous sample high, current low.
    assign fall = s3_q & ~s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            // Line-side flops reset to the idle level so release of reset
            // cannot look like a start bit.
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            flag_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            flag_cnt_q  <= flag_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        s1_d        = rxd;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        // Flag hold counter runs independently of the frame FSM; a reload
        // below overrides the decrement.
        flag_cnt_d  = (flag_cnt_q != '0) ? flag_cnt_q - 16'd1 : '0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d   = s2_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d                  = '0;
                    shift_d[bit_cnt_q[2:0]]    = s2_q;
                    bit_cnt_d                  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (s2_q) begin
                        // Return to IDLE at mid stop bit so a following
                        // start bit is caught even with a one-bit stop.
                        rx_data_d  = shift_q;
                        flag_cnt_d = FLAG_LOAD;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            BREAK: begin
                // Absorb a held-low line so it raises only one framing error.
                clk_cnt_d = '0;
                if (s2_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_flag   = (flag_cnt_q != '0);
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_module.sv
module tb_uart_rx_module;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       frame_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         flag_hi;
    int         err_hi;
    int         busy_hi;
    int         flag_rises;
    int         flag_rise_cyc;
    logic       flag_prev = 1'b0;
    logic [7:0] got[$];

    uart_rx_module #(
        .CLKS_PER_BIT (16),
        .HALF_BIT     (8),
        .FLAG_HOLD    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_flag   (rx_flag),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_flag) flag_hi++;
        if (rx_flag && !flag_prev) begin
            flag_rises++;
            if (flag_rise_cyc < 0) flag_rise_cyc = cyc;
            got.push_back(rx_data);
        end
        flag_prev = rx_flag;
        if (frame_err) err_hi++;
        if (rx_busy) busy_hi++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic clear_mon();
        flag_hi       = 0;
        err_hi        = 0;
        busy_hi       = 0;
        flag_rises    = 0;
        flag_rise_cyc = -1;
        got.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int jit_at(input int k, input bit en);
        if (!en || k == 0 || k == 10) return 0;
        return (k % 2 == 1) ? 2 : -2;
    endfunction

    // Drives start, 8 data bits LSB first, stop; leaves rxd at the stop level.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit, input bit jit);
        logic [9:0] lv;
        int dur;
        lv = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = lv[k];
            dur = per + jit_at(k + 1, jit) - jit_at(k, jit);
            repeat (dur) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", rx_flag); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst_n = 1'b1;
        clear_mon();
        idle(20);
        checks++; if (busy_hi !== 0) begin failures++; $display("FAIL post_reset_busy: got %0d busy cycles expected 0", busy_hi); end
        checks++; if (flag_hi !== 0) begin failures++; $display("FAIL post_reset_flag: got %0d flag cycles expected 0", flag_hi); end
    endtask

    task automatic test_frame_a5();
        int start;
        clear_mon();
        start = cyc;
        send_frame(8'hA5, CPB, 1'b1, 1'b0);
        rxd = 1'b1;
        idle(40);
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h expected a5", rx_data); end
        checks++; if (flag_rises !== 1) begin failures++; $display("FAIL a5_rises: got %0d expected 1", flag_rises); end
        checks++; if (flag_hi !== 4) begin failures++; $display("FAIL a5_flag_len: got %0d expected 4", flag_hi); end
        checks++; if (flag_rise_cyc !== start + 155) begin failures++; $display("FAIL a5_flag_time: got %0d expected %0d", flag_rise_cyc - start, 155); end
        checks++; if (err_hi !== 0) begin failures++; $display("FAIL a5_err: got %0d expected 0", err_hi); end
        checks++; if (busy_hi !== 152) begin failures++; $display("FAIL a5_busy_len: got %0d expected 152", busy_hi); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        checks++; if (flag_hi !== 0) begin failures++; $display("FAIL glitch_flag: got %0d expected 0", flag_hi); end
        checks++; if (err_hi !== 0) begin failures++; $display("FAIL glitch_err: got %0d expected 0", err_hi); end
        checks++; if (busy_hi !== 8) begin failures++; $display("FAIL glitch_busy_len: got %0d expected 8", busy_hi); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL glitch_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h3C, CPB, 1'b0, 1'b0);
        idle(40);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy_low: got %b expected 1", rx_busy); end
        rxd = 1'b1;
        idle(2);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy_sync: got %b expected 1", rx_busy); end
        idle(1);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_busy_exit: got %b expected 0", rx_busy); end
        idle(20);
        checks++; if (err_hi !== 1) begin failures++; $display("FAIL ferr_pulse: got %0d cycles expected 1", err_hi); end
        checks++; if (flag_hi !== 0) begin failures++; $display("FAIL ferr_flag: got %0d expected 0", flag_hi); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL ferr_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, CPB, 1'b1, 1'b0);
        send_frame(8'hFF, CPB, 1'b1, 1'b0);
        rxd = 1'b1;
        idle(40);
        checks++; if (flag_rises !== 2) begin failures++; $display("FAIL b2b_rises: got %0d expected 2", flag_rises); end
        if (got.size() >= 2) begin
            checks++; if (got[0] !== 8'h00) begin failures++; $display("FAIL b2b_first: got %h expected 00", got[0]); end
            checks++; if (got[1] !== 8'hFF) begin failures++; $display("FAIL b2b_second: got %h expected ff", got[1]); end
        end
        checks++; if (err_hi !== 0) begin failures++; $display("FAIL b2b_err: got %0d expected 0", err_hi); end
        checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL b2b_data: got %h expected ff", rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] lv;
        clear_mon();
        lv = {1'b1, 8'h5A, 1'b0};
        for (int k = 0; k < 5; k++) begin
            rxd = lv[k];
            idle(CPB);
        end
        rst_n = 1'b0;
        for (int k = 5; k < 10; k++) begin
            rxd = lv[k];
            idle(CPB / 2);
            if (k == 5) begin
                checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
                checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
                checks++; if (rx_flag !== 1'b0) begin failures++; $display("FAIL midrst_flag: got %b expected 0", rx_flag); end
                checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b expected 0", frame_err); end
            end
            idle(CPB - CPB / 2);
        end
        rst_n = 1'b1;
        idle(30);
        checks++; if (flag_hi !== 0) begin failures++; $display("FAIL midrst_noflag: got %0d expected 0", flag_hi); end
        clear_mon();
        send_frame(8'h81, CPB, 1'b1, 1'b0);
        rxd = 1'b1;
        idle(40);
        checks++; if (flag_rises !== 1) begin failures++; $display("FAIL postrst_rises: got %0d expected 1", flag_rises); end
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL postrst_data: got %h expected 81", rx_data); end
        checks++; if (err_hi !== 0) begin failures++; $display("FAIL postrst_err: got %0d expected 0", err_hi); end
    endtask

    task automatic test_jitter();
        clear_mon();
        send_frame(8'h55, CPB, 1'b1, 1'b1);
        rxd = 1'b1;
        idle(40);
        checks++; if (flag_rises !== 1) begin failures++; $display("FAIL jitter_rises: got %0d expected 1", flag_rises); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL jitter_data: got %h expected 55", rx_data); end
        checks++; if (err_hi !== 0) begin failures++; $display("FAIL jitter_err: got %0d expected 0", err_hi); end
    endtask

    task automatic test_baud_extremes();
        int per;
        int n;
        for (int i = 0; i < 2; i++) begin
            per = (i == 0) ? 15 : 17;
            clear_mon();
            send_frame(8'h55, per, 1'b1, 1'b0);
            rxd = 1'b1;
            n = 0;
            while ((rx_busy || rx_flag) && n < 400) begin
                @(negedge clk);
                n++;
            end
            idle(20);
            checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL baud_%0d_idle: busy %b expected 0", per, rx_busy); end
            $display("INFO period %0d: flags=%0d errors=%0d last_data=%h", per, flag_rises, err_hi, rx_data);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_jitter();
        test_baud_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
